ma_stage: RTL
=============

// Module: ma_stage
// PURPOSE
//  Memory-access stage of the 32-bit pipelined core; sits directly downstream of EX and feeds RW.
//  Holds the EX/MA pipeline register and drives the data-memory handshake for ld/st.
//  Produces the MA/RW register contents and stalls upstream stages while an access is outstanding.
//  Non-memory instructions pass through with one register stage.
// PARAMETERS
//  AW        32  data-memory address width (word-aligned byte address)
//  TIMEOUT   15  max cycles waiting for mem_ack before aborting (4-bit counter)
// PORTS
//  clk          in   1   core clock, rising edge
//  reset_n      in   1   asynchronous reset, active low
//  ex_valid     in   1   EX presents a valid instruction this cycle
//  ex_aluresult in   32  EX AluResult1 (ld/st effective address or ALU value)
//  ex_op2       in   32  store data (Op2 from EX)
//  ex_pc        in   32  PC of the instruction
//  ex_rd        in   4   destination register index
//  ex_isld      in   1   load
//  ex_isst      in   1   store
//  ex_iswb      in   1   writes back a register
//  ex_iscall    in   1   call (RW writes PC+4 to ra)
//  ma_stall     out  1   high: EX/upstream must hold; ex_* not captured
//  mem_req      out  1   data-memory request
//  mem_we       out  1   1 = write, 0 = read; valid while mem_req
//  mem_addr     out  AW  word-aligned address; valid while mem_req
//  mem_wdata    out  32  store data; valid while mem_req
//  mem_ack      in   1   memory completes the access this cycle
//  mem_rdata    in   32  load data, valid with mem_ack
//  rw_valid     out  1   MA/RW register holds a valid instruction
//  rw_aluresult out  32  registered ALU result
//  rw_ldresult  out  32  registered load data (0 for non-loads)
//  rw_pc        out  32  registered PC
//  rw_rd        out  4   registered destination
//  rw_iswb      out  1   registered write-back enable (forced 0 on error)
//  rw_isld      out  1   registered load flag
//  rw_iscall    out  1   registered call flag
//  ma_err       out  1   one-cycle pulse: misaligned address or timeout
// BEHAVIOUR
//  Reset (reset_n=0, async): all outputs 0, EX/MA valid=0, FSM=IDLE, timeout counter=0.
//  EX/MA register loads ex_* on a clk edge when ma_stall=0; ex_valid=0 loads a bubble.
//  FSM states: IDLE, ACCESS.
//   IDLE: if EX/MA valid and (isld|isst) and addr[1:0]==0 -> ACCESS, ma_stall=1.
//         Else (non-mem or bubble) -> next edge moves entry to MA/RW; ma_stall=0.
//   ACCESS: mem_req=1, addr/we/wdata held stable, ma_stall=1, counter++ each cycle.
//         mem_ack=1 -> MA/RW loads entry (rw_ldresult=mem_rdata if ld), FSM->IDLE;
//         ma_stall drops the same cycle as mem_ack (combinational) so EX advances.
//         counter reaches TIMEOUT without ack -> ma_err pulse, entry retired with rw_iswb=0, ->IDLE.
//  Misaligned ld/st (addr[1:0]!=0): no mem_req, ma_err pulse, entry retired with rw_iswb=0.
//  Latency: non-mem ex_valid edge -> rw_valid 1 cycle later; mem op -> rw_valid the edge after mem_ack.
//  mem_req never asserted for two different accesses back-to-back without returning through IDLE.
//  mem_ack while not in ACCESS is ignored. Both isld and isst set: treated as store.
//  rw_* update only when an entry retires; otherwise rw_valid=0 next cycle, other rw_* hold.
//  Reset mid-access: mem_req drops immediately, entry discarded, no ma_err.
//  Counter clears on entry to ACCESS; saturates, never wraps.
// TESTING
//  ALU op: ex_valid, aluresult=0x1234, iswb=1, rd=3 -> next cycle rw_valid=1, rw_aluresult=0x1234, ma_stall=0.
//  Load 0x100, ack after 3 cycles, rdata=0xDEADBEEF -> mem_req 3 cycles, ma_stall=1, rw_ldresult=0xDEADBEEF.
//  Store 0x200 data 0xA5A5A5A5, ack immediately -> mem_we=1, mem_wdata=0xA5A5A5A5, one-cycle stall.
//  Load 0x102 -> no mem_req, ma_err=1 one cycle, rw_iswb=0.
//  Load with no ack -> mem_req held TIMEOUT cycles, then ma_err, FSM IDLE, stall released.
//  reset_n low during ACCESS -> mem_req=0, rw_valid=0 immediately; next ALU op completes normally.

Source files
------------

// File: rtl/ma_stage.sv
// Memory-access stage: holds the EX/MA pipeline register, runs the data-memory
// handshake for loads and stores, and produces the MA/RW register contents.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no access outstanding; a non-memory or errored entry retires
//        | at the next edge, and an aligned ld/st starts an access
// ACCESS | mem_req held with a stable address and data until mem_ack
//        | arrives or the timeout counter expires
module ma_stage #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ex_valid,
    input  logic [31:0]   ex_aluresult,
    input  logic [31:0]   ex_op2,
    input  logic [31:0]   ex_pc,
    input  logic [3:0]    ex_rd,
    input  logic          ex_isld,
    input  logic          ex_isst,
    input  logic          ex_iswb,
    input  logic          ex_iscall,
    output logic          ma_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          rw_valid,
    output logic [31:0]   rw_aluresult,
    output logic [31:0]   rw_ldresult,
    output logic [31:0]   rw_pc,
    output logic [3:0]    rw_rd,
    output logic          rw_iswb,
    output logic          rw_isld,
    output logic          rw_iscall,
    output logic          ma_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } stateT;

    // The counter holds the number of ACCESS cycles already spent, so the
    // access gives up in the cycle where it reads TIMEOUT-1; that keeps
    // mem_req high for exactly TIMEOUT cycles.
    localparam logic [3:0] toLast = 4'(TIMEOUT - 1);

    stateT       state;
    logic [3:0]  toCnt;

    logic        entryValid;
    logic [31:0] entryAlu;
    logic [31:0] entryOp2;
    logic [31:0] entryPc;
    logic [3:0]  entryRd;
    logic        entryIsLd;
    logic        entryIsSt;
    logic        entryIsWb;
    logic        entryIsCall;

    logic        entryMem;
    logic        entryAligned;
    logic        entryLoadOnly;
    logic        startAccess;
    logic        ackHit;
    logic        toHit;
    logic        retire;
    logic        retireErr;

    // Decode of the held entry and the handshake events of this cycle.
    always_comb begin
        entryMem      = entryValid & (entryIsLd | entryIsSt);
        entryAligned  = (entryAlu[1:0] == 2'b00);
        // A ld/st with both flags set behaves as a store.
        entryLoadOnly = entryIsLd & ~entryIsSt;
        startAccess   = (state == IDLE) & entryMem & entryAligned;
        ackHit        = (state == ACCESS) & mem_ack;
        toHit         = (state == ACCESS) & ~mem_ack & (toCnt == toLast);
        retire        = ((state == IDLE) & entryValid & ~startAccess) | ackHit | toHit;
        retireErr     = ((state == IDLE) & entryMem & ~entryAligned) | toHit;
        // Stall drops in the completing cycle so EX advances into the slot
        // freed by the retiring entry.
        ma_stall      = startAccess | ((state == ACCESS) & ~ackHit & ~toHit);
    end

    // Memory bus is a pure decode of the held entry, so it stays stable
    // for the whole access and is quiet outside ACCESS.
    always_comb begin
        mem_req   = (state == ACCESS);
        mem_we    = mem_req & entryIsSt;
        mem_addr  = mem_req ? {entryAlu[AW-1:2], 2'b00} : '0;
        mem_wdata = mem_req ? entryOp2 : 32'h0;
    end

    // Access sequencer with its saturating timeout counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            toCnt <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    toCnt <= 4'h0;
                    if (startAccess) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (toCnt != 4'hF) begin
                        toCnt <= toCnt + 4'h1;
                    end
                    if (ackHit || toHit) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    toCnt <= 4'h0;
                end
            endcase
        end
    end

    // EX/MA pipeline register; captures EX (or a bubble) whenever not stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entryValid  <= 1'b0;
            entryAlu    <= 32'h0;
            entryOp2    <= 32'h0;
            entryPc     <= 32'h0;
            entryRd     <= 4'h0;
            entryIsLd   <= 1'b0;
            entryIsSt   <= 1'b0;
            entryIsWb   <= 1'b0;
            entryIsCall <= 1'b0;
        end else if (!ma_stall) begin
            entryValid  <= ex_valid;
            entryAlu    <= ex_aluresult;
            entryOp2    <= ex_op2;
            entryPc     <= ex_pc;
            entryRd     <= ex_rd;
            entryIsLd   <= ex_isld;
            entryIsSt   <= ex_isst;
            entryIsWb   <= ex_iswb;
            entryIsCall <= ex_iscall;
        end
    end

    // MA/RW register: written only when an entry retires, otherwise only
    // the valid bit drops and the payload holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rw_valid     <= 1'b0;
            rw_aluresult <= 32'h0;
            rw_ldresult  <= 32'h0;
            rw_pc        <= 32'h0;
            rw_rd        <= 4'h0;
            rw_iswb      <= 1'b0;
            rw_isld      <= 1'b0;
            rw_iscall    <= 1'b0;
            ma_err       <= 1'b0;
        end else begin
            rw_valid <= retire;
            ma_err   <= retire & retireErr;
            if (retire) begin
                rw_aluresult <= entryAlu;
                rw_ldresult  <= (ackHit & entryLoadOnly) ? mem_rdata : 32'h0;
                rw_pc        <= entryPc;
                rw_rd        <= entryRd;
                rw_iswb      <= entryIsWb & ~retireErr;
                rw_isld      <= entryLoadOnly;
                rw_iscall    <= entryIsCall;
            end
        end
    end

endmodule
